// File: rtl/pad_conv_pkg.sv
// Shared types and elaboration helpers for the padded KxK window generator.
package pad_conv_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Bits needed to count 0..v-1; never returns less than 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // Border padding adds (K-1)/2 on each side, i.e. K-1 in total.
  function automatic int pad_dim(input int n, input int k);
    return n + k - 1;
  endfunction

  function automatic int win_idx(input int i, input int j, input int k, input int dw);
    return (i * k + j) * dw;
  endfunction

endpackage

// File: rtl/pad_line_buf.sv
// Enable-gated row delay: o_dout is the sample pushed DEPTH enabled cycles earlier.
module pad_line_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 30
) (
  input  logic              i_clk,
  input  logic              i_en,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      r_mem[0] <= i_din;
      for (int d = 1; d < DEPTH; d++) begin
        r_mem[d] <= r_mem[d-1];
      end
    end
  end

  assign o_dout = r_mem[DEPTH-1];

endmodule

// File: rtl/pad_window_stream.sv
// Streaming KxK "same"-padded window generator; walks the padded raster and
// injects zeros at border positions so the consumer sees IMG_H*IMG_W windows.
module pad_window_stream
  import pad_conv_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28,
  parameter int K      = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     in_pix,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [K*K*DATA_W-1:0] win,
  output logic                  win_valid,
  input  logic                  win_ready,
  output logic                  win_last,
  output logic                  busy
);

  localparam int P     = (K - 1) / 2;
  localparam int WP    = pad_dim(IMG_W, K);
  localparam int HP    = pad_dim(IMG_H, K);
  localparam int CW    = clog2(WP);
  localparam int RW    = clog2(HP);
  localparam int WIN_W = K * K * DATA_W;

  localparam logic [CW-1:0] C_LO   = CW'(P);
  localparam logic [CW-1:0] C_HI   = CW'(P + IMG_W);
  localparam logic [CW-1:0] C_EMIT = CW'(K - 1);
  localparam logic [CW-1:0] C_LAST = CW'(WP - 1);
  localparam logic [RW-1:0] R_LO   = RW'(P);
  localparam logic [RW-1:0] R_HI   = RW'(P + IMG_H);
  localparam logic [RW-1:0] R_EMIT = RW'(K - 1);
  localparam logic [RW-1:0] R_LAST = RW'(HP - 1);

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; valid never waits on ready, and a raised valid holds its data
  // stable until that transfer.

  state_e            r_state;
  logic [RW-1:0]     r_row;
  logic [CW-1:0]     r_col;
  logic [WIN_W-1:0]  r_win;
  logic              r_win_valid;
  logic              r_win_last;
  logic [DATA_W-1:0] r_wsr [K][K];

  logic              w_run;
  logic              w_real;
  logic              w_room;
  logic              w_adv;
  logic              w_emit;
  logic              w_last_pos;
  logic [DATA_W-1:0] w_tap [K];
  logic [DATA_W-1:0] w_next [K][K];
  logic [WIN_W-1:0]  w_next_win;

  assign w_run      = (r_state == RUN);
  assign w_real     = (r_row >= R_LO) && (r_row < R_HI) && (r_col >= C_LO) && (r_col < C_HI);
  assign w_room     = !r_win_valid || win_ready;
  assign w_adv      = w_run && w_room && (!w_real || in_valid);
  assign w_emit     = w_adv && (r_row >= R_EMIT) && (r_col >= C_EMIT);
  assign w_last_pos = (r_row == R_LAST) && (r_col == C_LAST);

  // Bottom window row takes the live sample; each line buffer supplies the
  // sample one padded row further up.
  assign w_tap[K-1] = w_real ? in_pix : '0;

  for (genvar gk = 0; gk < K - 1; gk++) begin : g_lb
    pad_line_buf #(
      .DATA_W (DATA_W),
      .DEPTH  (WP)
    ) u_lb (
      .i_clk  (clk),
      .i_en   (w_adv),
      .i_din  (w_tap[K-1-gk]),
      .o_dout (w_tap[K-2-gk])
    );
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_row
    for (genvar gj = 0; gj < K; gj++) begin : g_col
      if (gj < K - 1) begin : g_shift
        assign w_next[gi][gj] = r_wsr[gi][gj+1];
      end else begin : g_new
        assign w_next[gi][gj] = w_tap[gi];
      end
      assign w_next_win[win_idx(gi, gj, K, DATA_W) +: DATA_W] = w_next[gi][gj];
    end
  end

  // Window shift registers are fully refilled within each padded row before
  // any window is emitted from them, so they need no reset.
  always_ff @(posedge clk) begin
    if (w_adv) begin
      r_wsr <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_win       <= '0;
      r_win_valid <= 1'b0;
      r_win_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_state <= RUN;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        RUN: begin
          if (w_adv) begin
            if (r_col == C_LAST) begin
              r_col <= '0;
              if (r_row == R_LAST) begin
                r_row   <= '0;
                r_state <= IDLE;
              end else begin
                r_row <= r_row + RW'(1);
              end
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
      endcase

      if (w_emit) begin
        r_win       <= w_next_win;
        r_win_valid <= 1'b1;
        r_win_last  <= w_last_pos;
      end else if (win_ready) begin
        r_win_valid <= 1'b0;
        r_win_last  <= 1'b0;
      end
    end
  end

  assign in_ready  = w_run && w_real && w_room;
  assign win       = r_win;
  assign win_valid = r_win_valid;
  assign win_last  = r_win_last;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_pad_window_stream.sv
// Scoreboarded bench: a K=3 4x4 instance and a K=5 6-wide 5-high instance.
module tb_pad_window_stream;

  localparam int DW   = 8;
  localparam int AK   = 3;
  localparam int AW   = 4;
  localparam int AH   = 4;
  localparam int AWIN = AK * AK * DW;
  localparam int BK   = 5;
  localparam int BW   = 6;
  localparam int BH   = 5;
  localparam int BWIN = BK * BK * DW;

  localparam int HW0  [9] = '{0, 0, 0, 0, 1, 2, 0, 5, 6};
  localparam int HW5  [9] = '{1, 2, 3, 5, 6, 7, 9, 10, 11};
  localparam int HW15 [9] = '{11, 12, 0, 15, 16, 0, 0, 0, 0};

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            a_rst, a_in_valid, a_in_ready, a_win_valid, a_win_ready, a_win_last, a_busy;
  logic [DW-1:0]   a_in_pix;
  logic [AWIN-1:0] a_win;
  logic            b_rst, b_in_valid, b_in_ready, b_win_valid, b_win_ready, b_win_last, b_busy;
  logic [DW-1:0]   b_in_pix;
  logic [BWIN-1:0] b_win;

  pad_window_stream #(.DATA_W(DW), .IMG_W(AW), .IMG_H(AH), .K(AK)) u_dut_a (
    .clk(clk), .rst(a_rst), .in_pix(a_in_pix), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .win(a_win), .win_valid(a_win_valid), .win_ready(a_win_ready), .win_last(a_win_last),
    .busy(a_busy)
  );

  pad_window_stream #(.DATA_W(DW), .IMG_W(BW), .IMG_H(BH), .K(BK)) u_dut_b (
    .clk(clk), .rst(b_rst), .in_pix(b_in_pix), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .win(b_win), .win_valid(b_win_valid), .win_ready(b_win_ready), .win_last(b_win_last),
    .busy(b_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [AWIN:0] exp_qa[$];
  logic [BWIN:0] exp_qb[$];
  bit a_chk  = 1'b1;
  bit a_hand = 1'b0;
  int a_idx  = 0;
  int a_acc  = 0;
  int b_idx  = 0;
  int b_frames = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] pix(input int base, input int w, input int y, input int x);
    return DW'(base + y * w + x + 1);
  endfunction

  function automatic logic [AWIN-1:0] ref_a(input int base, input int r, input int c);
    logic [AWIN-1:0] v;
    v = '0;
    for (int i = 0; i < AK; i++) begin
      for (int j = 0; j < AK; j++) begin
        int y;
        int x;
        y = r + i - 1;
        x = c + j - 1;
        if (y >= 0 && y < AH && x >= 0 && x < AW) v[(i*AK+j)*DW +: DW] = pix(base, AW, y, x);
      end
    end
    return v;
  endfunction

  function automatic logic [BWIN-1:0] ref_b(input int base, input int r, input int c);
    logic [BWIN-1:0] v;
    v = '0;
    for (int i = 0; i < BK; i++) begin
      for (int j = 0; j < BK; j++) begin
        int y;
        int x;
        y = r + i - 2;
        x = c + j - 2;
        if (y >= 0 && y < BH && x >= 0 && x < BW) v[(i*BK+j)*DW +: DW] = pix(base, BW, y, x);
      end
    end
    return v;
  endfunction

  function automatic logic [AWIN-1:0] pack9(input int e [9]);
    logic [AWIN-1:0] v;
    for (int k = 0; k < 9; k++) v[k*DW +: DW] = DW'(e[k]);
    return v;
  endfunction

  task automatic push_frame_a(input int base);
    for (int r = 0; r < AH; r++)
      for (int c = 0; c < AW; c++)
        exp_qa.push_back({(r == AH - 1 && c == AW - 1), ref_a(base, r, c)});
  endtask

  task automatic push_frame_b(input int base);
    for (int r = 0; r < BH; r++)
      for (int c = 0; c < BW; c++)
        exp_qb.push_back({(r == BH - 1 && c == BW - 1), ref_b(base, r, c)});
  endtask

  // ---------------- drivers ----------------
  task automatic send_a(input int base, input int n, input int gap);
    int idx;
    int t;
    bit acc;
    idx = 0;
    t = 0;
    while (idx < n && t < 2000) begin
      a_in_valid = ($urandom_range(99) >= gap);
      a_in_pix   = pix(base, AW, idx / AW, idx % AW);
      @(negedge clk);
      acc = a_in_valid && a_in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      t++;
    end
    a_in_valid = 1'b0;
    if (t >= 2000) chk("a_send_timeout", idx, n);
  endtask

  task automatic send_b(input int n);
    int idx;
    int t;
    bit acc;
    idx = 0;
    t = 0;
    while (idx < n && t < 4000) begin
      b_in_valid = 1'b1;
      b_in_pix   = DW'((idx / (BW * BH)) * 100 + (idx % (BW * BH)) + 1);
      @(negedge clk);
      acc = b_in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
      t++;
    end
    b_in_valid = 1'b0;
    if (t >= 4000) chk("b_send_timeout", idx, n);
  endtask

  task automatic stall_a();
    int base;
    int t;
    logic [AWIN-1:0] capt;
    base = a_acc;
    t = 0;
    while (a_acc < base + 3 && t < 300) begin
      @(posedge clk);
      t++;
    end
    #1;
    a_win_ready = 1'b0;
    t = 0;
    while (!a_win_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("stall_valid", a_win_valid, 1);
    capt = a_win;
    repeat (5) begin
      @(negedge clk);
      chk("stall_win_stable", a_win, capt);
      chk("stall_valid_held", a_win_valid, 1);
      chk("stall_in_ready", a_in_ready, 0);
    end
    @(posedge clk);
    #1;
    a_win_ready = 1'b1;
  endtask

  task automatic drain_a(input string name);
    int t;
    t = 0;
    while ((exp_qa.size() != 0 || a_busy || a_win_valid) && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_pending"}, exp_qa.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain_b();
    int t;
    t = 0;
    while ((exp_qb.size() != 0 || b_busy || b_win_valid) && t < 800) begin
      @(negedge clk);
      t++;
    end
    chk("b_pending", exp_qb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_a(input string name);
    chk({name, "_win_valid"}, a_win_valid, 0);
    chk({name, "_win_last"}, a_win_last, 0);
    chk({name, "_in_ready"}, a_in_ready, 0);
    chk({name, "_busy"}, a_busy, 0);
    chk({name, "_win"}, a_win, 0);
  endtask

  // ---------------- scoreboard monitors ----------------
  always @(negedge clk) begin
    if (!a_rst) begin
      a_idx = 0;
    end else if (a_win_valid && a_win_ready) begin
      if (a_chk) begin
        if (exp_qa.size() == 0) begin
          chk("a_unexpected_window", {a_win_last, a_win}, 0);
        end else begin
          chk("a_window", {a_win_last, a_win}, exp_qa.pop_front());
        end
        if (a_hand) begin
          if (a_idx == 0)  chk("a_hand_first", a_win, pack9(HW0));
          if (a_idx == 5)  chk("a_hand_centre11", a_win, pack9(HW5));
          if (a_idx == 15) chk("a_hand_last", {a_win_last, a_win}, {1'b1, pack9(HW15)});
        end
      end
      a_acc++;
      a_idx = a_win_last ? 0 : a_idx + 1;
    end
  end

  always @(negedge clk) begin
    if (!b_rst) begin
      b_idx = 0;
    end else if (b_win_valid && b_win_ready) begin
      if (exp_qb.size() == 0) begin
        chk("b_unexpected_window", {b_win_last, b_win}, 0);
      end else begin
        chk("b_window", {b_win_last, b_win}, exp_qb.pop_front());
      end
      if (b_idx == 0) begin
        logic [BWIN-1:0] m;
        m = '0;
        for (int i = 0; i < BK; i++)
          for (int j = 0; j < BK; j++)
            if (i < 2 || j < 2) m[(i*BK+j)*DW +: DW] = '1;
        chk("b_corner_border", b_win & m, 0);
        chk("b_corner_e22", b_win[12*DW +: DW], b_frames * 100 + 1);
        chk("b_corner_e24", b_win[14*DW +: DW], b_frames * 100 + 3);
        chk("b_corner_e44", b_win[24*DW +: DW], b_frames * 100 + 15);
      end
      if (b_win_last) begin
        chk("b_busy_at_last", b_busy, 0);
        b_frames++;
        b_idx = 0;
      end else begin
        b_idx++;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- sequence ----------------
  initial begin
    a_rst = 1'b0; a_in_valid = 1'b0; a_in_pix = '0; a_win_ready = 1'b1;
    b_rst = 1'b0; b_in_valid = 1'b0; b_in_pix = '0; b_win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    a_in_valid = 1'b1;
    #1;
    check_reset_a("reset");
    chk("b_reset_busy", b_busy, 0);
    chk("b_reset_win_valid", b_win_valid, 0);
    a_in_valid = 1'b0;
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    b_rst = 1'b1;
    @(posedge clk);
    #1;

    a_hand = 1'b1;
    push_frame_a(0);
    send_a(0, AW * AH, 0);
    drain_a("clean");
    a_hand = 1'b0;

    push_frame_a(0);
    fork
      send_a(0, AW * AH, 0);
      stall_a();
    join
    drain_a("stall");

    push_frame_a(0);
    send_a(0, AW * AH, 50);
    drain_a("gappy");

    a_chk = 1'b0;
    send_a(200, 7, 0);
    a_rst = 1'b0;
    @(posedge clk);
    #1;
    check_reset_a("mid_reset");
    a_rst = 1'b1;
    a_chk = 1'b1;
    a_hand = 1'b1;
    push_frame_a(0);
    send_a(0, AW * AH, 0);
    drain_a("post_reset");
    a_hand = 1'b0;

    push_frame_b(0);
    push_frame_b(100);
    send_b(2 * BW * BH);
    drain_b();
    chk("b_frames_seen", b_frames, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
